// File: rtl/food_placer_if.sv
// food_placer_if: random-generator and collision-checker signals seen by the food placer.
interface food_placer_if #(parameter int BIT = 10);
    logic           rnd_trigger;
    logic [BIT-1:0] rnd_x;
    logic [BIT-1:0] rnd_y;
    logic           chk_valid;
    logic [BIT-1:0] chk_x;
    logic [BIT-1:0] chk_y;
    logic           chk_ready;
    logic           chk_hit;
    modport master (output rnd_trigger, chk_valid, chk_x, chk_y, input rnd_x, rnd_y, chk_ready, chk_hit);
    modport slave  (input rnd_trigger, chk_valid, chk_x, chk_y, output rnd_x, rnd_y, chk_ready, chk_hit);
endinterface

// File: rtl/food_placer.sv
// food_placer: picks a grid-aligned random food cell, retrying on snake collisions.
// FOOD_TIMEOUT_EN adds automatic relocation after TIMEOUT_TICKS idle frames.
module food_placer #(
    parameter int BIT           = 10,
    parameter int GRID_LOG2     = 3,
    parameter int MAX_TRIES     = 8,
    parameter int RESET_X       = 200,
    parameter int RESET_Y       = 240,
    parameter int TIMEOUT_TICKS = 600
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            place_req,
    input  logic            frame_tick,
    food_placer_if.master   bus,
    output logic [BIT-1:0]  food_x,
    output logic [BIT-1:0]  food_y,
    output logic            busy,
    output logic            placed,
    output logic            place_fail
);
    typedef enum logic [2:0] {IDLE, TRIG, SETTLE, SAMPLE, CHECK} state_t;
    state_t     state;
    logic       pending;
    logic [7:0] tries;
    logic       req;
    logic       unused_ok;
    assign unused_ok = &{1'b0, bus.rnd_x[GRID_LOG2-1:0], bus.rnd_y[GRID_LOG2-1:0]};
`ifdef FOOD_TIMEOUT_EN
    logic [15:0] frame_cnt;
    logic        tmo;
    assign tmo = state == IDLE && frame_tick && frame_cnt == 16'(TIMEOUT_TICKS - 1);
    assign req = place_req | tmo;
    always_ff @(posedge clk) begin
        if (!reset || placed || place_fail || tmo)
            frame_cnt <= '0;
        else if (state == IDLE && frame_tick)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    logic unused_tick;
    assign unused_tick = frame_tick;
    assign req = place_req;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            food_x          <= BIT'(RESET_X);
            food_y          <= BIT'(RESET_Y);
            bus.rnd_trigger <= 1'b0;
            bus.chk_valid   <= 1'b0;
            bus.chk_x       <= '0;
            bus.chk_y       <= '0;
            busy            <= 1'b0;
            placed          <= 1'b0;
            place_fail      <= 1'b0;
            pending         <= 1'b0;
            tries           <= '0;
        end else begin
            placed     <= 1'b0;
            place_fail <= 1'b0;
            if (state != IDLE && place_req)
                pending <= 1'b1;
            case (state)
                IDLE: if (req || pending) begin
                    state           <= TRIG;
                    pending         <= 1'b0;
                    tries           <= '0;
                    bus.rnd_trigger <= 1'b1;
                    busy            <= 1'b1;
                end
                TRIG: begin
                    state           <= SETTLE;
                    bus.rnd_trigger <= 1'b0;
                end
                SETTLE: state <= SAMPLE;
                SAMPLE: begin
                    bus.chk_x     <= {bus.rnd_x[BIT-1:GRID_LOG2], {GRID_LOG2{1'b0}}};
                    bus.chk_y     <= {bus.rnd_y[BIT-1:GRID_LOG2], {GRID_LOG2{1'b0}}};
                    tries         <= tries + 8'(tries != 8'hff);
                    bus.chk_valid <= 1'b1;
                    state         <= CHECK;
                end
                CHECK: if (bus.chk_ready) begin
                    bus.chk_valid <= 1'b0;
                    if (!bus.chk_hit) begin
                        food_x <= bus.chk_x;
                        food_y <= bus.chk_y;
                        placed <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (tries < 8'(MAX_TRIES)) begin
                        state           <= TRIG;
                        bus.rnd_trigger <= 1'b1;
                    end else begin
                        place_fail <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed checks of placement latency, retries, failure, stalls, pending and reset.
module tb_food_placer;
    logic       clk = 1'b0;
    logic       reset, place_req, frame_tick;
    logic [9:0] food_x, food_y;
    logic       busy, placed, place_fail;
    int         errors = 0, checks = 0;
    int         trig_hi = 0, trig_rise = 0, n_qry = 0, n_placed = 0, n_fail = 0;
    logic       trig_prev = 1'b0;
    int         b_hi, b_rise, b_qry, b_placed, b_fail, fail_at;
    logic       ok;
    logic [9:0] hold_x, hold_y;

    food_placer_if #(.BIT(10)) bus ();

    food_placer #(.TIMEOUT_TICKS(3)) dut (
        .clk(clk), .reset(reset), .place_req(place_req), .frame_tick(frame_tick), .bus(bus),
        .food_x(food_x), .food_y(food_y), .busy(busy), .placed(placed), .place_fail(place_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        trig_hi   <= trig_hi + int'(bus.rnd_trigger);
        trig_rise <= trig_rise + int'(bus.rnd_trigger && !trig_prev);
        trig_prev <= bus.rnd_trigger;
        n_qry     <= n_qry + int'(bus.chk_valid && bus.chk_ready);
        n_placed  <= n_placed + int'(placed);
        n_fail    <= n_fail + int'(place_fail);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        #4;
        b_hi = trig_hi; b_rise = trig_rise; b_qry = n_qry; b_placed = n_placed; b_fail = n_fail;
        #1;
    endtask

    initial begin
        reset = 1'b0; place_req = 1'b0; frame_tick = 1'b0;
        bus.rnd_x = 10'd203; bus.rnd_y = 10'd245; bus.chk_ready = 1'b1; bus.chk_hit = 1'b0;
        repeat (3) step();
        check("reset_food_x", food_x, 200);
        check("reset_food_y", food_y, 240);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy || placed || place_fail || bus.rnd_trigger || bus.chk_valid || food_x != 10'd200 || food_y != 10'd240)
                ok = 1'b0;
        end
        check("idle_quiet", ok, 1);

        // single hit-free placement, latency 5
        snap();
        place_req = 1'b1; step(); place_req = 1'b0;
        check("c1_trigger", bus.rnd_trigger, 1);
        check("c1_busy", busy, 1);
        step();
        check("c2_trigger_low", bus.rnd_trigger, 0);
        repeat (2) step();
        check("c4_valid", bus.chk_valid, 1);
        check("c4_chk_x", bus.chk_x, 200);
        check("c4_chk_y", bus.chk_y, 240);
        step();
        check("c5_placed", placed, 1);
        check("c5_busy", busy, 0);
        check("c5_valid_low", bus.chk_valid, 0);
        check("c5_food_x", food_x, 200);
        check("c5_food_y", food_y, 240);
        step(); snap();
        check("single_trig_cycles", b_hi, 1);

        // two collisions then success with a new random value
        bus.chk_hit = 1'b1;
        place_req = 1'b1; step(); place_req = 1'b0;
        repeat (3) step();
        check("retry_q1_x", bus.chk_x, 200);
        repeat (4) step();
        check("retry_q2_valid", bus.chk_valid, 1);
        step();
        bus.chk_hit = 1'b0; bus.rnd_x = 10'd331; bus.rnd_y = 10'd97;
        repeat (3) step();
        check("retry_q3_x", bus.chk_x, 328);
        check("retry_q3_y", bus.chk_y, 96);
        step();
        check("retry_placed", placed, 1);
        check("retry_food_x", food_x, 328);
        check("retry_food_y", food_y, 96);
        step();
        #4;
        check("retry_trig_cycles", trig_hi - b_hi, 3);
        check("retry_trig_rises", trig_rise - b_rise, 3);
        check("retry_placed_once", n_placed - b_placed, 1);
        #1;

        // every candidate collides: MAX_TRIES queries then failure
        snap();
        bus.chk_hit = 1'b1; bus.rnd_x = 10'd203; bus.rnd_y = 10'd245;
        place_req = 1'b1; step(); place_req = 1'b0;
        fail_at = -1;
        for (int c = 2; c < 100; c++) begin
            step();
            if (place_fail) begin
                fail_at = c;
                break;
            end
        end
        check("fail_cycle", fail_at, 33);
        check("fail_busy_low", busy, 0);
        check("fail_food_x", food_x, 328);
        check("fail_food_y", food_y, 96);
        step();
        #4;
        check("fail_queries", n_qry - b_qry, 8);
        check("fail_no_placed", n_placed - b_placed, 0);
        check("fail_pulse_once", n_fail - b_fail, 1);
        #1;

        // stalled checker, requests while busy collapse into one follow-up
        snap();
        bus.chk_hit = 1'b0; bus.chk_ready = 1'b0; bus.rnd_x = 10'd17; bus.rnd_y = 10'd9;
        place_req = 1'b1; step(); place_req = 1'b0;
        repeat (3) step();
        check("stall_valid", bus.chk_valid, 1);
        hold_x = bus.chk_x; hold_y = bus.chk_y;
        check("stall_chk_x", hold_x, 16);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            place_req = (i == 2 || i == 5);
            step();
            if (!bus.chk_valid || bus.chk_x != hold_x || bus.chk_y != hold_y || placed)
                ok = 1'b0;
        end
        place_req = 1'b0;
        check("stall_stable", ok, 1);
        bus.chk_ready = 1'b1;
        step();
        check("stall_placed", placed, 1);
        check("stall_food_x", food_x, 16);
        check("stall_food_y", food_y, 8);
        repeat (20) step();
        #4;
        check("pending_placements", n_placed - b_placed, 2);
        check("pending_triggers", trig_hi - b_hi, 2);
        #1;
        check("pending_idle", busy, 0);

        // reset in the middle of CHECK
        snap();
        bus.chk_ready = 1'b0; bus.rnd_x = 10'd100; bus.rnd_y = 10'd60;
        place_req = 1'b1; step(); place_req = 1'b0;
        repeat (3) step();
        check("rst_in_check", bus.chk_valid, 1);
        reset = 1'b0;
        step();
        check("rst_valid", bus.chk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_trigger", bus.rnd_trigger, 0);
        check("rst_chk_x", bus.chk_x, 0);
        check("rst_food_x", food_x, 200);
        check("rst_food_y", food_y, 240);
        check("rst_pulses", {placed, place_fail}, 0);
        reset = 1'b1; bus.chk_ready = 1'b1;
        repeat (10) step();
        #4;
        check("rst_no_pulse", (n_placed - b_placed) + (n_fail - b_fail), 0);
        #1;

        // frame ticks while idle
        snap();
        for (int k = 0; k < 3; k++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        repeat (10) step();
        #4;
`ifdef FOOD_TIMEOUT_EN
        check("timeout_placed", n_placed - b_placed, 1);
`else
        check("timeout_placed", n_placed - b_placed, 0);
`endif
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
